// File: rtl/booth_mult_scheduler.sv
// booth_mult_scheduler: two-requester front end for a radix-2 Booth multiplier.
// One operand pair is multiplied at a time over WIDTH cycles. The result is
// held until the consumer takes it.
// Optional feature macro: BOOTH_SCHED_ROUND_ROBIN_EN. When it is defined, ties
// are broken round-robin. When it is undefined, requester 0 has fixed priority.
module booth_mult_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_x,
  input  logic [WIDTH-1:0]     req0_y,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_x,
  input  logic [WIDTH-1:0]     req1_y,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_product,
  output logic                 res_id,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   a;        // one guard bit so a most-negative M cannot overflow
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    count;
  logic             id;
  logic             grant;
  logic             accept;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   a_sum;

`ifdef BOOTH_SCHED_ROUND_ROBIN_EN
  logic last_grant;

  // Round-robin tie break: the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = ~req0_valid;
  end

  // Remember the winner of each accept. After reset, requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`else
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    grant = ~req0_valid;
  end
`endif

  assign req0_ready  = (state == IDLE) && req0_valid && !grant;
  assign req1_ready  = (state == IDLE) && req1_valid &&  grant;
  assign accept      = req0_ready | req1_ready;
  assign busy        = (state != IDLE);
  assign res_valid   = (state == DONE);
  assign res_product = {a[WIDTH-1:0], q};
  assign res_id      = id;
  assign m_ext       = {m[WIDTH-1], m};

  // Booth recoding of {Q[0], q_1}: 10 subtracts M, 01 adds M, otherwise A is kept.
  always_comb begin
    a_sum = a;
    case ({q[0], q_1})
      2'b10:   a_sum = a - m_ext;
      2'b01:   a_sum = a + m_ext;
      default: a_sum = a;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: the last Booth step (count == 1) lands in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (count == CW'(1)) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the operands on accept, then do one step and one arithmetic shift per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      id    <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        m     <= grant ? req1_x : req0_x;
        q     <= grant ? req1_y : req0_y;
        a     <= '0;
        q_1   <= 1'b0;
        count <= CW'(WIDTH);
        id    <= grant;
      end
    end else if (state == RUN) begin
      a     <= {a_sum[WIDTH], a_sum[WIDTH:1]};
      q     <= {a_sum[0], q[WIDTH-1:1]};
      q_1   <= q[0];
      count <= count - CW'(1);
    end
  end

endmodule
